uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single simpleuart transmit port among NREQ byte requesters (e.g. CPU console, debug module, trace dumper).
- Round-robin arbitration with packet lock: once granted, a requester owns the UART until it sends a byte flagged last, or until its lock times out.
- Drives the UART data-write handshake (we/di, stalled by wait) and exposes per-requester valid/ready.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, idle cycles of the lock owner before forced release; 0 disables the timeout.
- TOW, 16, width of the timeout counter; must hold LOCK_TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i].
- req_last  in  NREQ  byte ends the requester's packet; releases the lock.
- req_ready  out  NREQ  byte accepted when valid&&ready.
- uart_dat_we  out  1  UART data write strobe.
- uart_dat_di  out  32  {24'b0, held byte}.
- uart_dat_wait  in  1  UART busy; a write completes on a cycle with we=1 and wait=0.
- grant_id  out  3  current/last owner index.
- locked  out  1  a packet lock is held.
- busy  out  1  byte held or lock held.

Behaviour:
- Reset values: req_ready=0, uart_dat_we=0, uart_dat_di=0, grant_id=0, locked=0, busy=0, rr pointer=NREQ-1 (requester 0 wins first), timeout counter=0.
- Reset is asynchronous. If it is asserted mid-send, we drops immediately and the held byte is discarded.
- States:
  - IDLE: no lock, hold empty.
  - LOCK: lock held, hold empty.
  - SEND_U: unlocked byte held.
  - SEND_L: locked byte held.
- IDLE:
  - Winner is the first i with req_valid[i], searching from ptr+1 upward with wrap.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On accept: byte goes to hold, grant_id=winner, and last goes to last_q.
  - Next state is SEND_U if req_last, else SEND_L with locked=1.
- LOCK:
  - req_ready[grant_id]=1 only; all other requesters are blocked.
  - On accept: go to SEND_L, timeout counter cleared.
  - While req_valid[grant_id]=0: counter increments.
  - When the counter reaches LOCK_TIMEOUT (nonzero): locked=0, ptr=grant_id, go to IDLE.
- SEND_U / SEND_L:
  - uart_dat_we=1 and uart_dat_di={24'b0,hold}; all req_ready are 0 (single-byte hold, no skid).
  - Completion is the first cycle with uart_dat_wait=0.
  - On completion, if last_q=1: locked=0, ptr=grant_id, go to IDLE.
  - On completion, if last_q=0: go to LOCK.
  - While wait=1: hold and we stay stable.
- Latency: a byte accepted in cycle N shows uart_dat_we=1 in cycle N+1.
  - With the UART idle, back-to-back locked bytes sustain 1 byte per 2 cycles at the arbiter. In practice the UART's wait throttles to line rate.
- Timeout counter is frozen outside LOCK and saturates at LOCK_TIMEOUT.
- A last byte from the owner takes priority over a timeout in the same cycle: the accept wins.
- ptr only updates at lock release, so fairness is per packet, not per byte.
- Requester deasserting valid before ready: nothing is accepted and there is no side effect.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined:
  - In IDLE, requester 0 wins unconditionally when valid; the remaining requesters use round-robin.
  - Locks and timeouts are unchanged; requester 0 cannot preempt an existing lock.
- Undefined: pure round-robin for all requesters as above.

Test Plan:
- Reset, then req_valid=4'b0001, data 0x41, last=1, wait=0:
  - accept in cycle 1; we=1 with di=0x00000041 in cycle 2; state returns to IDLE; locked stays 0.
- req_valid=4'b1111, all bytes last=1, wait=0:
  - grant order 0,1,2,3,0.
  - with UART_TX_ARB_PRIO0_EN defined: order 0,0,0 while req0 stays valid.
- Requester 2 sends 0x10,0x11 (last=0) then 0x12 (last=1) while requester 1 stays valid:
  - uart sees 0x10,0x11,0x12 consecutively; req1 ready stays 0 until after 0x12; grant then goes to 3 if valid, else 1.
- Hold uart_dat_wait=1 for 20 cycles during a send:
  - we and di stay stable for 20 cycles; all req_ready=0; completion occurs on the first cycle with wait=0.
- LOCK_TIMEOUT=8: requester 1 sends 0x55 with last=0 then goes silent:
  - locked drops exactly 8 cycles after entering LOCK; requester 0 is then granted.
- Assert reset during SEND_L:
  - we=0 and locked=0 asynchronously; after release, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one simpleuart transmit port among NREQ byte requesters.
// Optional build macro UART_TX_ARB_PRIO0_EN: requester 0 wins any idle arbitration whenever it is valid.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TOW          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                uart_dat_we,
  output logic [31:0]         uart_dat_di,
  input  logic                uart_dat_wait,
  output logic [2:0]          grant_id,
  output logic                locked,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK   = 2'd1,
    S_SEND_U = 2'd2,
    S_SEND_L = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_hold;
  logic [7:0]      w_hold_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic [2:0]      r_grant;
  logic [2:0]      w_grant_nxt;
  logic [2:0]      r_ptr;
  logic [2:0]      w_ptr_nxt;
  logic [TOW-1:0]  r_cnt;
  logic [TOW-1:0]  w_cnt_nxt;
  logic [TOW-1:0]  w_cnt_inc;
  logic            r_we;
  logic            r_locked;
  logic            r_busy;

  logic            w_any;
  logic            w_hit;
  logic [2:0]      w_winner;
  logic [2:0]      w_sel;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic [7:0]      w_sel_data;
  logic [NREQ-1:0] w_ready;

  // Idle winner: first valid requester after the pointer, wrapping around.
  always_comb begin
    w_any    = 1'b0;
    w_hit    = 1'b0;
    w_winner = 3'd0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        w_hit    = !w_any && req_valid[i] && (i == ((int'(r_ptr) + k) % NREQ));
        w_winner = w_hit ? 3'(i) : w_winner;
        w_any    = w_any | w_hit;
      end
    end
`ifdef UART_TX_ARB_PRIO0_EN
    w_winner = req_valid[0] ? 3'd0 : w_winner;
    w_any    = w_any | req_valid[0];
`endif
  end

  // Select the candidate requester's valid/data/last (idle winner or lock owner).
  always_comb begin
    w_sel       = (r_state == S_IDLE) ? w_winner : r_grant;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      w_sel_valid = (3'(i) == w_sel) ? req_valid[i]        : w_sel_valid;
      w_sel_last  = (3'(i) == w_sel) ? req_last[i]         : w_sel_last;
      w_sel_data  = (3'(i) == w_sel) ? req_data[8*i +: 8]  : w_sel_data;
    end
  end

  assign w_cnt_inc = r_cnt + TOW'(1);

  // Next-state, hold capture, lock timeout and pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = (3'(i) == w_winner);
          end
          w_hold_nxt  = w_sel_data;
          w_last_nxt  = w_sel_last;
          w_grant_nxt = w_winner;
          w_state_nxt = w_sel_last ? S_SEND_U : S_SEND_L;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCK: begin
        for (int i = 0; i < NREQ; i++) begin
          w_ready[i] = (3'(i) == r_grant);
        end
        // An accept in the same cycle as the timeout wins over the release.
        if (w_sel_valid) begin
          w_hold_nxt  = w_sel_data;
          w_last_nxt  = w_sel_last;
          w_cnt_nxt   = TOW'(0);
          w_state_nxt = S_SEND_L;
        end else if ((LOCK_TIMEOUT != 0) && (w_cnt_inc >= TOW'(LOCK_TIMEOUT))) begin
          w_cnt_nxt   = TOW'(0);
          w_ptr_nxt   = r_grant;
          w_state_nxt = S_IDLE;
        end else if (LOCK_TIMEOUT != 0) begin
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      S_SEND_U, S_SEND_L: begin
        if (!uart_dat_wait) begin
          if (r_last) begin
            w_ptr_nxt   = r_grant;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOCK;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any held byte immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_hold   <= 8'h00;
      r_last   <= 1'b0;
      r_grant  <= 3'd0;
      r_ptr    <= 3'(NREQ - 1);
      r_cnt    <= TOW'(0);
      r_we     <= 1'b0;
      r_locked <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_hold_nxt;
      r_last   <= w_last_nxt;
      r_grant  <= w_grant_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_we     <= (w_state_nxt == S_SEND_U) || (w_state_nxt == S_SEND_L);
      r_locked <= (w_state_nxt == S_LOCK) || (w_state_nxt == S_SEND_L);
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign req_ready   = w_ready;
  assign uart_dat_we = r_we;
  assign uart_dat_di = {24'h000000, r_hold};
  assign grant_id    = r_grant;
  assign locked      = r_locked;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: transaction-level arbitration model plus a UART-side monitor.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int LT   = 8;
  localparam int TOW  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                uart_dat_we;
  logic [31:0]         uart_dat_di;
  logic                uart_dat_wait;
  logic [2:0]          grant_id;
  logic                locked;
  logic                busy;

  uart_tx_arbiter #(.NREQ(NREQ), .LOCK_TIMEOUT(LT), .TOW(TOW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .grant_id      (grant_id),
    .locked        (locked),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sbq[$];
  logic [8:0] rq[NREQ][$];
  int gap_pct = 0;
  int stall_pct = 0;
  bit force_wait = 1'b0;
  logic [NREQ-1:0] acc = '0;

  // Reference model: owner (-1 when unlocked), pending byte, rr pointer, idle count.
  int m_owner = -1;
  int m_grant = 0;
  int m_ptr = NREQ - 1;
  int m_idle = 0;
  bit m_full = 1'b0;
  bit m_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef UART_TX_ARB_PRIO0_EN
    if (req_valid[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_accept(input int w);
    m_grant = w;
    m_last  = req_last[w];
    m_full  = 1'b1;
    sbq.push_back({3'(w), req_data[8*w +: 8]});
  endtask

  // Model: check control outputs against the model, then advance it by one cycle.
  always @(negedge clk) begin : model
    logic [NREQ-1:0] e_ready;
    int win;
    if (reset) begin
      m_owner = -1; m_grant = 0; m_ptr = NREQ - 1; m_idle = 0;
      m_full = 1'b0; m_last = 1'b0;
      sbq.delete();
    end else begin
      e_ready = '0;
      check("we", 32'(uart_dat_we), 32'(m_full));
      check("locked", 32'(locked), 32'(m_owner >= 0));
      check("busy", 32'(busy), 32'(m_full || (m_owner >= 0)));
      check("grant_id", 32'(grant_id), 32'(m_grant));
      if (m_full) begin
        if (!uart_dat_wait) begin
          m_full = 1'b0;
          if (m_last) begin
            m_owner = -1;
            m_ptr   = m_grant;
          end
        end
      end else if (m_owner >= 0) begin
        e_ready = NREQ'(1 << m_owner);
        if (req_valid[m_owner]) begin
          model_accept(m_owner);
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == LT) begin
            m_ptr   = m_owner;
            m_owner = -1;
            m_idle  = 0;
          end
        end
      end else begin
        win = pick();
        if (win >= 0) begin
          e_ready = NREQ'(1 << win);
          model_accept(win);
          m_owner = m_last ? -1 : win;
        end
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
    end
  end

  // Monitor: every cycle the UART write strobe is up, compare against the queue head.
  always @(negedge clk) begin
    if (!reset && (uart_dat_we === 1'b1)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: write of %0h with no expected byte at %0t", uart_dat_di, $time);
      end else begin
        check("uart_di", uart_dat_di, {24'h000000, sbq[0].data});
        if (uart_dat_wait === 1'b0) begin
          check("grant_at_write", 32'(grant_id), 32'(sbq[0].id));
          void'(sbq.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    acc <= reset ? '0 : (req_valid & req_ready);
  end

  task automatic push_pkt(input int r, input int len, input logic [7:0] b0);
    for (int j = 0; j < len; j++) begin
      rq[r].push_back({(j == len - 1), b0 + 8'(j)});
    end
  endtask

  task automatic step();
    logic [8:0] h;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && (rq[i].size() > 0)) void'(rq[i].pop_front());
      if ((rq[i].size() > 0) && ($urandom_range(0, 99) >= gap_pct)) begin
        h = rq[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    uart_dat_wait = force_wait || ($urandom_range(0, 99) < stall_pct);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) return 1'b1;
    end
    return m_full || (m_owner >= 0);
  endfunction

  task automatic drain();
    int t = 0;
    while (pending() && (t < 3000)) begin
      step();
      t++;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_bad++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", t);
    end
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    uart_dat_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single byte from requester 0, no lock.
    push_pkt(0, 1, 8'h41);
    drain();

    // All four valid with single-byte packets: strict rotation.
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < NREQ; r++) push_pkt(r, 1, 8'(16 * r + p));
    end
    drain();

    // Requester 2 locks for a 3-byte packet while requester 1 waits.
    push_pkt(2, 3, 8'h10);
    step();
    push_pkt(1, 1, 8'h21);
    drain();

    // UART stalls for 20 cycles during a send.
    force_wait = 1'b1;
    push_pkt(3, 1, 8'hA5);
    repeat (22) step();
    force_wait = 1'b0;
    drain();

    // Lock timeout: requester 1 goes silent mid-packet, requester 0 waits.
    push_pkt(1, 2, 8'h55);
    rq[1].delete();
    rq[1].push_back({1'b0, 8'h55});
    step();
    step();
    step();
    push_pkt(0, 1, 8'h66);
    drain();

    // Asynchronous reset during a locked send.
    force_wait = 1'b1;
    push_pkt(2, 2, 8'h70);
    step();
    step();
    step();
    check("pre_rst_we", 32'(uart_dat_we), 32'd1);
    check("pre_rst_locked", 32'(locked), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_we", 32'(uart_dat_we), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    req_valid = '0;
    force_wait = 1'b0;
    uart_dat_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_pkt(3, 1, 8'h33);
    push_pkt(0, 1, 8'h30);
    drain();

    // Randomized traffic with gaps and UART stalls.
    gap_pct = 20;
    stall_pct = 30;
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ((rq[r].size() < 6) && ($urandom_range(0, 99) < 6)) begin
          push_pkt(r, int'($urandom_range(1, 4)), 8'($urandom));
        end
      end
      step();
    end
    gap_pct = 0;
    stall_pct = 0;
    drain();

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
